// File: rtl/mult_div_unit.sv
// Iterative signed MULT (radix-2 Booth) / DIV (restoring) engine owning HI/LO; one bit per cycle.
// start -> done is 33 cycles (1 cycle for DIV by zero); start is ignored unless IDLE.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] ALUSrcA,
  input  logic [WIDTH-1:0] ALUSrcB,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  state_t           state_q, state_d;
  logic             op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   m_ext, booth_sum, rem_sh, trial;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    qm1_d    = qm1_q;
    m_d      = m_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    a_abs = ALUSrcA[WIDTH-1] ? -ALUSrcA : ALUSrcA;
    b_abs = ALUSrcB[WIDTH-1] ? -ALUSrcB : ALUSrcB;

    // Hi accumulator is one bit wider so subtracting the most negative multiplicand cannot overflow.
    m_ext = {m_q[WIDTH-1], m_q};
    case ({acc_lo_q[0], qm1_q})
      2'b01:   booth_sum = acc_hi_q + m_ext;
      2'b10:   booth_sum = acc_hi_q - m_ext;
      default: booth_sum = acc_hi_q;
    endcase

    rem_sh = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, m_q};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d   = op;
          cnt_d  = CW'(WIDTH - 1);
          dz_d   = 1'b0;
          busy_d = 1'b1;
          qm1_d  = 1'b0;
          acc_hi_d = '0;
          if (op) begin
            acc_lo_d = a_abs;
            m_d      = b_abs;
            negq_d   = ALUSrcA[WIDTH-1] ^ ALUSrcB[WIDTH-1];
            negr_d   = ALUSrcA[WIDTH-1];
            if (ALUSrcB == '0) begin
              dz_d    = 1'b1;
              state_d = S_FINISH;
            end else begin
              state_d = S_RUN;
            end
          end else begin
            acc_lo_d = ALUSrcB;
            m_d      = ALUSrcA;
            state_d  = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (op_q) begin
          if (!trial[WIDTH]) begin
            acc_hi_d = trial;
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi_d = rem_sh;
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_hi_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
          acc_lo_d = {booth_sum[0], acc_lo_q[WIDTH-1:1]};
          qm1_d    = acc_lo_q[0];
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = S_FINISH;
      end
      S_FINISH: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        // A divide by zero leaves HI/LO untouched.
        if (!dz_q) begin
          if (op_q) begin
            lo_d = negq_q ? -acc_lo_q : acc_lo_q;
            hi_d = negr_q ? -acc_hi_q[WIDTH-1:0] : acc_hi_q[WIDTH-1:0];
          end else begin
            hi_d = acc_hi_q[WIDTH-1:0];
            lo_d = acc_lo_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      op_q     <= 1'b0;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      qm1_q    <= 1'b0;
      m_q      <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      qm1_q    <= qm1_d;
      m_q      <= m_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign HI       = hi_q;
  assign LO       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table plus hand sequences for the multi-cycle corners.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] ALUSrcA, ALUSrcB;
  logic        busy, done, div_zero;
  logic [31:0] HI, LO;

  int checks = 0;
  int failures = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .busy(busy), .done(done), .div_zero(div_zero), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Start one op; optionally pulse a spurious start k cycles in. Returns start->done latency.
  task automatic do_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                       input int glitch_at, output int lat, output logic busy_ok);
    @(negedge clk);
    op = o; ALUSrcA = a; ALUSrcB = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    busy_ok = busy;
    for (int k = 1; k <= 100; k++) begin
      if (k == glitch_at) begin
        start = 1'b1; op = 1'b1; ALUSrcA = 32'd100; ALUSrcB = 32'd7;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int   lat;
    logic bok;
    do_op(v.op, v.a, v.b, -1, lat, bok);
    if (lat < 0) begin
      checks++; failures++;
      $display("FAIL %s timeout: done never seen within 100 cycles", tag);
    end else begin
      check({tag, " latency"}, 64'(lat), 64'(v.lat));
      check({tag, " busy_during"}, 64'(bok), 64'd1);
      check({tag, " busy_at_done"}, 64'(busy), 64'd0);
      check({tag, " HI"}, 64'(HI), 64'(v.hi));
      check({tag, " LO"}, 64'(LO), 64'(v.lo));
      check({tag, " div_zero"}, 64'(div_zero), 64'(v.dz));
    end
  endtask

  initial begin
    int   lat;
    logic bok;

    vecs[0]  = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 33};
    vecs[1]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 33};
    vecs[2]  = '{1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0, 33};
    vecs[3]  = '{1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 33};
    vecs[4]  = '{1'b0, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 33};
    vecs[5]  = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33};
    vecs[6]  = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 33};
    vecs[7]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33};
    vecs[8]  = '{1'b1, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 33};
    vecs[9]  = '{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd14,        1'b0, 33};
    vecs[10] = '{1'b1, 32'd5,         32'd10,        32'd5,         32'd0,         1'b0, 33};
    vecs[11] = '{1'b1, 32'h7FFF_FFFF, 32'd1,         32'd0,         32'h7FFF_FFFF, 1'b0, 33};
    vecs[12] = '{1'b0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33};
    // Divide by zero keeps the previous MULT result in HI/LO.
    vecs[13] = '{1'b1, 32'd9,         32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1, 1};

    reset = 1'b0; start = 1'b0; op = 1'b0; ALUSrcA = '0; ALUSrcB = '0;
    #12;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset div_zero", 64'(div_zero), 64'd0);
    check("reset HI", 64'(HI), 64'd0);
    check("reset LO", 64'(LO), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 14; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // div_zero is sticky while idle, then cleared by the next accepted start.
    repeat (3) @(negedge clk);
    check("dz sticky", 64'(div_zero), 64'd1);
    check("dz HI kept", 64'(HI), 64'hFFFF_FFFF);
    check("dz LO kept", 64'(LO), 64'hFFFF_FFEB);
    run_vec("after_dz", '{1'b0, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 33});

    // Spurious start mid-MULT must not restart or redirect the operation.
    do_op(1'b0, 32'hFFFF_FFFF, 32'd5, 5, lat, bok);
    check("glitch latency", 64'(lat), 64'd33);
    check("glitch busy_during", 64'(bok), 64'd1);
    check("glitch HI", 64'(HI), 64'hFFFF_FFFF);
    check("glitch LO", 64'(LO), 64'hFFFF_FFFB);
    repeat (3) @(negedge clk);
    check("glitch idle after", 64'(busy), 64'd0);

    // Asynchronous reset at iteration 10 aborts immediately.
    @(negedge clk);
    op = 1'b0; ALUSrcA = 32'd1234; ALUSrcB = 32'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("arst busy", 64'(busy), 64'd0);
    check("arst done", 64'(done), 64'd0);
    check("arst HI", 64'(HI), 64'd0);
    check("arst LO", 64'(LO), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check("arst no late done", 64'(LO), 64'd0);
    run_vec("post_reset", '{1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
